// File: rtl/exhaustive_equiv_checker.sv
// exhaustive_equiv_checker
//
// Sweeps every WIDTH-bit vector onto a shared stimulus bus, holds each for DWELL cycles,
// and compares two combinational implementations (dut_a_i vs dut_b_i) on the last cycle of
// each dwell. Counts mismatching vectors (saturating), captures the first failing vector
// and reports pass/fail when the sweep completes.
//
// Ports:
//   clk_i              system clock, rising edge
//   reset_i            synchronous active-high reset; all outputs return to 0
//   start_i            begin a sweep (honoured in idle or done only)
//   stop_on_fail_i     latched at start: end the sweep at the first mismatch
//   dut_a_i, dut_b_i   outputs of the two implementations under comparison
//   test_vec_o         stimulus vector driven to both implementations
//   busy_o             sweep in progress
//   done_o             sweep finished, held until start or reset
//   pass_o             valid with done_o: no mismatches seen
//   mismatch_count_o   number of mismatching vectors, saturating
//   first_fail_vec_o   first vector that mismatched
//   first_fail_valid_o first_fail_vec_o holds a captured vector
module exhaustive_equiv_checker #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DWELL = 5,
  parameter int unsigned OUTS  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stop_on_fail_i,
  input  logic [OUTS-1:0]  dut_a_i,
  input  logic [OUTS-1:0]  dut_b_i,
  output logic [WIDTH-1:0] test_vec_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] mismatch_count_o,
  output logic [WIDTH-1:0] first_fail_vec_o,
  output logic             first_fail_valid_o
);

  // Dwell counter needs at least one bit even when DWELL == 1.
  localparam int unsigned DwW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DwW-1:0] DwellLast = DwW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [DwW-1:0]   dwell_q;
  logic             stop_q;
  logic [WIDTH-1:0] vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] ff_vec_q;
  logic             ff_valid_q;

  logic             cmp_edge;
  logic             mismatch;
  logic             finish;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cmp_edge = (state_q == StRun) && (dwell_q == DwellLast);
    mismatch = cmp_edge && (dut_a_i != dut_b_i);
    cnt_d    = (mismatch && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    // Sweep ends at the all-ones vector, or early on a mismatch when requested.
    finish   = (vec_q == '1) || (stop_q && mismatch);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      dwell_q    <= '0;
      stop_q     <= 1'b0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      cnt_q      <= '0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q    <= StRun;
            dwell_q    <= '0;
            stop_q     <= stop_on_fail_i;
            vec_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            cnt_q      <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
          end
        end
        StRun: begin
          dwell_q <= dwell_q + 1'b1;
          if (cmp_edge) begin
            cnt_q <= cnt_d;
            if (mismatch && !ff_valid_q) begin
              ff_vec_q   <= vec_q;
              ff_valid_q <= 1'b1;
            end
            if (finish) begin
              // vec_q is left on the last compared vector.
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (cnt_d == '0);
            end else begin
              vec_q   <= vec_q + 1'b1;
              dwell_q <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign test_vec_o         = vec_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign mismatch_count_o   = cnt_q;
  assign first_fail_vec_o   = ff_vec_q;
  assign first_fail_valid_o = ff_valid_q;

endmodule
